// File: rtl/ifetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode hand-off,
// redirect inputs and the observable PC state of the sequencer.
interface ifetch_sequencer_if #(
  parameter int ADDR_W = 30
);
  // Handshake rules:
  // - imem_req/imem_addr form a request.
  // - imem_ready returns the word for imem_addr in the same cycle.
  // - A word transfers to decode only when imem_req & imem_ready & ~stall
  //   with no redirect; instr_valid marks exactly those cycles.
  // - An unaccepted word is requested again at the same address.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              stall;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] redir_pc;
  logic              branch_taken;
  logic [15:0]       branch_offset;
  logic              jump;
  logic [25:0]       jump_target;
  logic              jr;
  logic [ADDR_W-1:0] jr_target;
  logic [1:0]        pc_src;
  logic [ADDR_W-1:0] pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_pc, pc_src, pc,
    input  imem_ready, stall, redir_pc, branch_taken, branch_offset,
           jump, jump_target, jr, jr_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_pc, pc_src, pc,
    output imem_ready, stall, redir_pc, branch_taken, branch_offset,
           jump, jump_target, jr, jr_target
  );
endinterface

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: owns the word-address PC, handshakes with
// instruction memory, and squashes the in-flight fetch on every redirect.
module ifetch_sequencer #(
  parameter int                ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  ifetch_sequencer_if.master bus,
  output logic [1:0]         state_dbg
);
  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_JR     = 2'd3;

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        src_q;

  logic              redirect;
  logic [ADDR_W-1:0] redir_plus1;
  logic [ADDR_W-1:0] target;
  logic [1:0]        target_src;
  logic              in_fetch;
  logic              accept;

  assign redirect    = bus.jr | bus.jump | bus.branch_taken;
  assign redir_plus1 = bus.redir_pc + ONE;

  // jr outranks jump, which outranks a taken branch.
  always_comb begin
    target     = redir_plus1 + {{(ADDR_W-16){bus.branch_offset[15]}}, bus.branch_offset};
    target_src = SRC_BRANCH;
    if (bus.jr) begin
      target     = bus.jr_target;
      target_src = SRC_JR;
    end else if (bus.jump) begin
      target     = {redir_plus1[ADDR_W-1:26], bus.jump_target};
      target_src = SRC_JUMP;
    end
  end

  assign in_fetch = ~reset & (state == S_FETCH);
  assign accept   = in_fetch & ~redirect & bus.imem_ready & ~bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      pc_q  <= RESET_PC;
      src_q <= SRC_SEQ;
    end else begin
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH: begin
          if (redirect) begin
            pc_q  <= target;
            src_q <= target_src;
            state <= S_FLUSH;
          end else if (bus.imem_ready && !bus.stall) begin
            pc_q  <= pc_q + ONE;
            src_q <= SRC_SEQ;
          end
        end
        S_FLUSH: begin
          // Any imem_ready here answers the squashed request and is dropped.
          if (redirect) begin
            pc_q  <= target;
            src_q <= target_src;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

  // Outputs are forced to their reset values for the whole reset cycle,
  // even before the first reset edge has been seen.
  logic [ADDR_W-1:0] pc_out;
  assign pc_out          = reset ? RESET_PC : pc_q;
  assign bus.pc          = pc_out;
  assign bus.imem_addr   = pc_out;
  assign bus.pc_src      = reset ? SRC_SEQ : src_q;
  assign bus.imem_req    = in_fetch;
  assign bus.instr_valid = accept;
  assign bus.instr_pc    = accept ? pc_q : '0;
  assign state_dbg       = state;
endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer: the stimulus process pushes expected outputs
// from a behavioural model; a negedge monitor pops and compares them.
module tb_ifetch_sequencer;
  localparam int AW = 30;
  localparam int W  = 1 + AW + 1 + AW + 2 + AW;
  localparam longint MASK = (longint'(1) << AW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ifetch_sequencer_if #(.ADDR_W(AW)) bus ();

  ifetch_sequencer #(.ADDR_W(AW), .RESET_PC('0)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: where the PC is, what picked it, and whether the
  // sequencer is just out of reset, fetching, or waiting out a squash.
  longint m_pc = 0;
  int     m_src = 0;
  bit     m_warmup = 1'b1;
  bit     m_squash = 1'b0;

  task automatic step(input bit rst, input bit rdy, input bit stl,
                      input bit br, input logic [15:0] off,
                      input bit jmp, input logic [25:0] jt,
                      input bit jrr, input logic [AW-1:0] jrt,
                      input logic [AW-1:0] rp);
    bit     e_req, e_val;
    longint e_ipc, e_pc, tgt, rp1;
    int     e_src, code;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.imem_ready    = rdy;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_offset = off;
    bus.jump          = jmp;
    bus.jump_target   = jt;
    bus.jr            = jrr;
    bus.jr_target     = jrt;
    bus.redir_pc      = rp;

    rp1 = (longint'(rp) + 1) & MASK;
    if (jrr) begin
      tgt = longint'(jrt); code = 3;
    end else if (jmp) begin
      tgt = (rp1 & (MASK - ((longint'(1) << 26) - 1))) | longint'(jt); code = 2;
    end else begin
      tgt = (rp1 + longint'($signed(off))) & MASK; code = 1;
    end

    e_req = 1'b0; e_val = 1'b0; e_ipc = 0;
    if (rst) begin
      e_pc = 0; e_src = 0;
      m_pc = 0; m_src = 0; m_warmup = 1'b1; m_squash = 1'b0;
    end else begin
      e_pc = m_pc; e_src = m_src;
      if (m_warmup) begin
        m_warmup = 1'b0;
      end else if (m_squash) begin
        if (br || jmp || jrr) begin
          m_pc = tgt; m_src = code;
        end else begin
          m_squash = 1'b0;
        end
      end else begin
        e_req = 1'b1;
        if (br || jmp || jrr) begin
          m_pc = tgt; m_src = code; m_squash = 1'b1;
        end else if (rdy && !stl) begin
          e_val = 1'b1; e_ipc = m_pc;
          m_pc = (m_pc + 1) & MASK; m_src = 0;
        end
      end
    end
    exp_q.push_back({e_req, AW'(e_pc), e_val, AW'(e_ipc), 2'(e_src), AW'(e_pc)});
  endtask

  task automatic plain(input bit rdy, input bit stl);
    step(1'b0, rdy, stl, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr_pc, bus.pc_src, bus.pc};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t req/addr/valid/ipc/src/pc act=%0b/%h/%0b/%h/%0d/%h exp=%0b/%h/%0b/%h/%0d/%h",
                 $time, a[W-1], a[W-2 -: AW], a[W-2-AW], a[W-3-AW -: AW], a[AW+1 -: 2], a[AW-1:0],
                 e[W-1], e[W-2 -: AW], e[W-2-AW], e[W-3-AW -: AW], e[AW+1 -: 2], e[AW-1:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_offset = '0;
    bus.jump = 1'b0; bus.jump_target = '0;
    bus.jr = 1'b0; bus.jr_target = '0; bus.redir_pc = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, '0, '0);
    // RST cycle, then words 0..4 accepted
    for (int i = 0; i < 6; i++) plain(1'b1, 1'b0);
    // stall at pc 5, then release
    for (int i = 0; i < 3; i++) plain(1'b1, 1'b1);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    // taken branch from 10, offset -4: target 7, stale ready in the flush
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, '0, 30'd10);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    // jr beats jump and branch, redirect also beats stall
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h55, 1'b1, 30'h100, 30'd20);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    // jump from the top word: PC+1 wraps so the upper bits are 0
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h2, 1'b0, '0, 30'h3FFFFFFF);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    // redirect during flush, then sequential wrap from the top word
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 30'h1234, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 30'h3FFFFFFF, '0);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    // stall and ready together: re-request at the same address
    plain(1'b1, 1'b1);
    plain(1'b0, 1'b0);
    plain(1'b1, 1'b0);
    // reset mid-fetch alongside a redirect
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h7, 1'b1, 26'h9, 1'b0, '0, 30'd40);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] rp, jrt;
      rp  = ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : AW'($urandom);
      jrt = ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : AW'($urandom);
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           16'($urandom),
           $urandom_range(0, 14) == 0,
           26'($urandom),
           $urandom_range(0, 19) == 0,
           jrt, rp);
    end

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_sequencer.md
# ifetch_sequencer

Instruction-fetch sequencer for the single-issue CPU's InstructionFetch stage. Owns the 30-bit word-address program counter and selects each cycle, via the 2:1 PC muxes, between sequential (PC+1), branch, jump and jump-register targets. Runs a request/ready handshake with instruction memory, honours downstream stall, and squashes in-flight fetches on redirect.

## Interface
- ADDR_W, 30, PC/word-address width
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  word address of request (= pc)
- imem_ready  in  1  memory returns word for imem_addr this cycle
- stall  in  1  decode cannot accept an instruction this cycle
- instr_valid  out  1  fetched word accepted by decode this cycle
- instr_pc  out  ADDR_W  address of accepted word (= pc when instr_valid)
- redir_pc  in  ADDR_W  address of the redirecting instruction
- branch_taken  in  1  taken conditional branch
- branch_offset  in  16  signed word offset
- jump  in  1  J/JAL
- jump_target  in  26  J-format target field
- jr  in  1  jump register
- jr_target  in  ADDR_W  register target (word address)
- pc_src  out  2  registered mux select of last PC update: 0 seq, 1 branch, 2 jump, 3 jr
- pc  out  ADDR_W  current program counter

## Operation
- Reset is synchronous, active-high. It has priority over every other input, including redirects, and is honoured in any state.
- On a reset edge: pc=RESET_PC, pc_src=0, state=RST.
- All outputs are 0 while reset is asserted, except pc=RESET_PC and imem_addr=pc.
- redirect = jr | jump | branch_taken. Priority is jr > jump > branch when more than one is asserted.
- Redirect targets, all arithmetic mod 2^ADDR_W:
  - branch: redir_pc + 1 + sext(branch_offset)
  - jump: {(redir_pc+1)[29:26], jump_target}
  - jr: jr_target
- FSM states:
  - RST: imem_req=0. Next state FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - redirect: pc <= target, pc_src <= code, instr_valid=0 (fetch squashed), next state FLUSH.
    - else if imem_ready & ~stall: instr_valid=1, instr_pc=pc, pc <= pc+1, pc_src <= 0, stay in FETCH.
    - else (not ready, or stalled): hold pc, keep requesting, instr_valid=0.
  - FLUSH: imem_req=0, instr_valid=0. Any imem_ready this cycle is a stale response and is ignored.
    - redirect in FLUSH: pc <= new target, stay in FLUSH one more cycle.
    - else next state FETCH.
- Sequential wrap: pc = 2^ADDR_W-1 advances to 0. No overflow flag.
- stall and imem_ready together with no redirect: word is not accepted and is re-requested next cycle at the same address.
- Redirect overrides stall: the pc update happens even while stall=1.

## Timing
- instr_valid and instr_pc are combinational from state, imem_ready, stall and redirect. pc and pc_src are registered.
- Zero-wait memory, no stall: one instruction per cycle, first instr_valid in the 2nd cycle after reset deasserts (RST, then FETCH).
- Redirect penalty: redirect in cycle N gives FLUSH in N+1 and a request at the target in N+2. Earliest target instr_valid is N+2.
- pc visible on the output the cycle after the update edge.

## Test plan
- Reset, then imem_ready=1, stall=0 for 4 cycles -> instr_valid high from cycle 2, instr_pc 0,1,2,3; pc_src=0 throughout.
- At pc=5, stall=1 for 3 cycles with imem_ready=1 -> instr_valid=0 and pc stays 5; after stall drops, instr_valid=1 with instr_pc=5, then 6.
- branch_taken with redir_pc=10, offset=-4 -> FLUSH cycle (imem_req=0, stale imem_ready ignored), next request at 7, pc_src=1.
- jr=1, jr_target=0x100, with jump=1 and branch_taken=1 in the same cycle -> pc=0x100, pc_src=3.
- jump with redir_pc=0x3FFFFFFF, jump_target=0x0000002 -> pc=0x00000002 (PC+1 wraps, upper bits 0); sequential fetch from 0x3FFFFFFF -> next pc 0.
- reset asserted mid-FETCH together with a redirect -> next cycle pc=RESET_PC, state RST, imem_req=0, instr_valid=0.
